// File: rtl/fetch_queue_pkg.sv
// Shared types and constants for the fetch queue.
// Optional same-cycle bypass is enabled by defining FETCH_QUEUE_BYPASS_EN
// (used in fetch_queue.sv).
package fetch_queue_pkg;

    // Default number of queue entries.
    localparam int unsigned FQ_DEPTH_DEFAULT = 4;

    // Widths of the fetched PC and instruction word.
    localparam int unsigned FQ_PC_W    = 32;
    localparam int unsigned FQ_INSTR_W = 32;

    // One fetched instruction travelling from fetch to issue.
    typedef struct packed {
        logic [FQ_PC_W-1:0]    pc;
        logic [FQ_INSTR_W-1:0] instr;
        logic                  prediction;  // 1 = predicted taken
    } pipe_in_t;

endpackage : fetch_queue_pkg

// File: rtl/fq_storage.sv
// Entry storage for the fetch queue: DEPTH x pipe_in_t registers with one
// write port, one asynchronous read port and a per-entry valid bit.
// Valid bits are set on write, cleared on dequeue of a single slot, and
// cleared all at once on flush or predicted-taken squash.
module fq_storage
    import fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH = FQ_DEPTH_DEFAULT,
    parameter int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             we_i,
    input  logic [PTR_W-1:0] waddr_i,
    input  pipe_in_t         wdata_i,
    input  logic             clr_one_i,
    input  logic [PTR_W-1:0] clr_addr_i,
    input  logic             clr_all_i,
    input  logic [PTR_W-1:0] raddr_i,
    output pipe_in_t         rdata_o,
    output logic             rvalid_o
);

    pipe_in_t         mem_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [DEPTH-1:0] vld_d;

    // Payload registers: written at the tail slot on enqueue.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // Next valid vector: clear-all dominates, a write to a slot wins over a
    // clear of the same slot.
    always_comb begin
        vld_d = vld_q;
        if (clr_all_i) begin
            vld_d = '0;
        end else begin
            if (clr_one_i) begin
                vld_d[clr_addr_i] = 1'b0;
            end
            if (we_i) begin
                vld_d[waddr_i] = 1'b1;
            end
        end
    end

    // Valid bit register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld_q <= '0;
        end else begin
            vld_q <= vld_d;
        end
    end

    assign rdata_o  = mem_q[raddr_i];
    assign rvalid_o = vld_q[raddr_i];

endmodule : fq_storage

// File: rtl/fetch_queue.sv
// In-order decoupling FIFO between fetch and issue.
// Handshake: fetch writes when wr_valid & wr_ready; issue consumes the head
// when rd_valid & rd_yumi (yumi is a commitment, not a request; yumi with
// rd_valid low is ignored). wr_ready depends only on registered occupancy.
// Defining FETCH_QUEUE_BYPASS_EN lets a write into an empty queue appear on
// the read side in the same cycle.
module fetch_queue
    import fetch_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = FQ_DEPTH_DEFAULT,
    localparam int unsigned PTR_W = $clog2(DEPTH)
) (
    input  logic           clk,
    input  logic           reset,
    input  logic           flush,
    input  logic           wr_valid,
    input  pipe_in_t       wr_data,
    output logic           wr_ready,
    output logic           rd_valid,
    output pipe_in_t       rd_data,
    input  logic           rd_yumi,
    output logic           taken_deq,
    output logic [PTR_W:0] count
);

    localparam int unsigned CNT_W = PTR_W + 1;

    logic [PTR_W-1:0] head_q, head_d;
    logic [PTR_W-1:0] tail_q, tail_d;
    logic [CNT_W-1:0] count_q, count_d;

    logic     full;
    logic     empty;
    logic     bypass;
    logic     enq;
    logic     deq;
    logic     enq_store;
    logic     deq_head;
    logic     store_we;
    logic     clr_all;
    logic     clr_head;
    pipe_in_t head_data;
    logic     head_vld;

    assign full  = (count_q == CNT_W'(DEPTH));
    assign empty = (count_q == '0);

    // Bypass is only possible into an empty queue and never during flush.
`ifdef FETCH_QUEUE_BYPASS_EN
    assign bypass = empty & wr_valid & ~flush;
`else
    assign bypass = 1'b0;
`endif

    assign wr_ready = ~full;
    assign rd_valid = head_vld | bypass;
    assign enq      = wr_valid & wr_ready;
    assign deq      = rd_valid & rd_yumi;

    // Read-side data: bypassed word, else head slot, else zero.
    always_comb begin
        rd_data = '0;
        if (bypass) begin
            rd_data = wr_data;
        end else if (head_vld) begin
            rd_data = head_data;
        end
    end

    assign taken_deq = deq & rd_data.prediction;

    // A bypassed word consumed in the same cycle is never stored, and a
    // bypassed read does not move the head.
    assign enq_store = enq & ~(bypass & deq);
    assign deq_head  = deq & ~bypass;

    // Pointer/occupancy next state: flush > taken squash > enqueue/dequeue.
    always_comb begin
        head_d   = head_q;
        tail_d   = tail_q;
        count_d  = count_q;
        store_we = 1'b0;
        clr_all  = 1'b0;
        clr_head = 1'b0;
        if (flush) begin
            // Wrong-path recovery: drop everything, head stays put.
            tail_d  = head_q;
            count_d = '0;
            clr_all = 1'b1;
        end else if (taken_deq) begin
            // Head issues as a taken branch; younger fall-through entries and
            // any same-cycle fetch are on the wrong path.
            count_d = '0;
            clr_all = 1'b1;
            if (!bypass) begin
                head_d = head_q + PTR_W'(1);
                tail_d = head_q + PTR_W'(1);
            end
        end else begin
            if (enq_store) begin
                store_we = 1'b1;
                tail_d   = tail_q + PTR_W'(1);
            end
            if (deq_head) begin
                clr_head = 1'b1;
                head_d   = head_q + PTR_W'(1);
            end
            case ({enq_store, deq_head})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Pointer and occupancy registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

    fq_storage #(
        .DEPTH (DEPTH),
        .PTR_W (PTR_W)
    ) u_storage (
        .clk        (clk),
        .rst_n      (reset),
        .we_i       (store_we),
        .waddr_i    (tail_q),
        .wdata_i    (wr_data),
        .clr_one_i  (clr_head),
        .clr_addr_i (head_q),
        .clr_all_i  (clr_all),
        .raddr_i    (head_q),
        .rdata_o    (head_data),
        .rvalid_o   (head_vld)
    );

endmodule : fetch_queue

// File: tb/tb_fetch_queue.sv
// Directed self-checking bench for fetch_queue (DEPTH=4).
module tb_fetch_queue;
    import fetch_queue_pkg::*;

    logic       clk;
    logic       reset;
    logic       flush;
    logic       wr_valid;
    pipe_in_t   wr_data;
    logic       wr_ready;
    logic       rd_valid;
    pipe_in_t   rd_data;
    logic       rd_yumi;
    logic       taken_deq;
    logic [2:0] count;

    int n_checks = 0;
    int n_fail   = 0;
    int n_viol   = 0;

    logic [31:0] exp_q[$];

    fetch_queue #(.DEPTH(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .flush     (flush),
        .wr_valid  (wr_valid),
        .wr_data   (wr_data),
        .wr_ready  (wr_ready),
        .rd_valid  (rd_valid),
        .rd_data   (rd_data),
        .rd_yumi   (rd_yumi),
        .taken_deq (taken_deq),
        .count     (count)
    );

    // Clock and reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Protocol monitor: yumi without a valid head.
    always @(negedge clk) begin
        if (reset && rd_yumi && !rd_valid) begin
            n_viol++;
            $display("protocol note: rd_yumi high with rd_valid low at %0t", $time);
        end
    end

    function automatic pipe_in_t mk(input logic [31:0] pc, input logic pred);
        pipe_in_t p;
        p.pc         = pc;
        p.instr      = ~pc;
        p.prediction = pred;
        return p;
    endfunction

    // Advance to just after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        flush    = 1'b0;
        wr_valid = 1'b0;
        wr_data  = '0;
        rd_yumi  = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b1;
        #1 reset = 1'b0;
        #1;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid: got %b want 0", rd_valid); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL reset_wr_ready: got %b want 1", wr_ready); end
        n_checks++; if (taken_deq !== 1'b0) begin n_fail++; $display("FAIL reset_taken_deq: got %b want 0", taken_deq); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL reset_count: got %0d want 0", count); end
        n_checks++; if (rd_data !== pipe_in_t'('0)) begin n_fail++; $display("FAIL reset_rd_data: got %h want 0", rd_data); end
        tick();
        tick();
        reset = 1'b1;
        tick();
    endtask

    task automatic test_in_order();
        for (int i = 0; i < 3; i++) begin
            wr_valid = 1'b1;
            wr_data  = mk(32'(4 * i), 1'b0);
`ifndef FETCH_QUEUE_BYPASS_EN
            if (i == 0) begin
                #1;
                n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL latency_same_cycle: rd_valid got %b want 0", rd_valid); end
            end
`endif
            tick();
            if (i == 0) begin
                n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL latency_next_cycle: rd_valid got %b want 1", rd_valid); end
            end
        end
        wr_valid = 1'b0;
        #1;
        n_checks++; if (count !== 3'd3) begin n_fail++; $display("FAIL inorder_count: got %0d want 3", count); end
        n_checks++; if (rd_data.pc !== 32'h00) begin n_fail++; $display("FAIL inorder_head: got %h want 00", rd_data.pc); end
        rd_yumi = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_checks++; if (rd_data.pc !== 32'(4 * i)) begin n_fail++; $display("FAIL inorder_deq%0d: got %h want %h", i, rd_data.pc, 4 * i); end
            tick();
        end
        rd_yumi = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL inorder_empty_count: got %0d want 0", count); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL inorder_empty_valid: got %b want 0", rd_valid); end
        n_checks++; if (rd_data !== pipe_in_t'('0)) begin n_fail++; $display("FAIL inorder_empty_data: got %h want 0", rd_data); end
    endtask

    task automatic test_full_wrap();
        logic do_enq;
        logic do_deq;
        exp_q.delete();
        for (int i = 0; i < 4; i++) begin
            wr_valid = 1'b1;
            wr_data  = mk(32'h10 + 32'(4 * i), 1'b0);
            #1;
            n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready%0d: got %b want 1", i, wr_ready); end
            exp_q.push_back(32'h10 + 32'(4 * i));
            tick();
        end
        wr_data = mk(32'h20, 1'b0);
        #1;
        n_checks++; if (wr_ready !== 1'b0) begin n_fail++; $display("FAIL full_ready: got %b want 0", wr_ready); end
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_count: got %0d want 4", count); end
        tick();
        n_checks++; if (count !== 3'd4) begin n_fail++; $display("FAIL full_hold_count: got %0d want 4", count); end
        for (int i = 0; i < 8; i++) begin
            wr_valid = 1'b1;
            wr_data  = mk(32'h30 + 32'(4 * i), 1'b0);
            rd_yumi  = 1'b1;
            #1;
            n_checks++; if (rd_data.pc !== exp_q[0]) begin n_fail++; $display("FAIL wrap_head%0d: got %h want %h", i, rd_data.pc, exp_q[0]); end
            n_checks++; if (wr_ready !== (exp_q.size() != 4)) begin n_fail++; $display("FAIL wrap_ready%0d: got %b want %b", i, wr_ready, exp_q.size() != 4); end
            do_enq = (exp_q.size() != 4);
            do_deq = (exp_q.size() != 0);
            if (do_deq) void'(exp_q.pop_front());
            if (do_enq) exp_q.push_back(32'h30 + 32'(4 * i));
            tick();
        end
        wr_valid = 1'b0;
        rd_yumi  = 1'b0;
        #1;
        n_checks++; if (count !== 3'(exp_q.size())) begin n_fail++; $display("FAIL wrap_count: got %0d want %0d", count, exp_q.size()); end
        while (exp_q.size() > 0) begin
            rd_yumi = 1'b1;
            #1;
            n_checks++; if (rd_data.pc !== exp_q[0]) begin n_fail++; $display("FAIL drain_head: got %h want %h", rd_data.pc, exp_q[0]); end
            void'(exp_q.pop_front());
            tick();
        end
        rd_yumi = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL drain_count: got %0d want 0", count); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL drain_valid: got %b want 0", rd_valid); end
    endtask

    task automatic test_taken_squash();
        wr_valid = 1'b1;
        wr_data  = mk(32'h20, 1'b1); tick();
        wr_data  = mk(32'h24, 1'b0); tick();
        wr_data  = mk(32'h28, 1'b0); tick();
        wr_data  = mk(32'h2C, 1'b0);
        rd_yumi  = 1'b1;
        #1;
        n_checks++; if (taken_deq !== 1'b1) begin n_fail++; $display("FAIL squash_taken: got %b want 1", taken_deq); end
        n_checks++; if (rd_data.pc !== 32'h20) begin n_fail++; $display("FAIL squash_head: got %h want 20", rd_data.pc); end
        tick();
        wr_valid = 1'b0;
        rd_yumi  = 1'b0;
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL squash_count: got %0d want 0", count); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL squash_valid: got %b want 0", rd_valid); end
        n_checks++; if (taken_deq !== 1'b0) begin n_fail++; $display("FAIL squash_taken_after: got %b want 0", taken_deq); end
        wr_valid = 1'b1;
        wr_data  = mk(32'h30, 1'b0);
        tick();
        wr_valid = 1'b0;
        #1;
        n_checks++; if (rd_data.pc !== 32'h30) begin n_fail++; $display("FAIL squash_refill_head: got %h want 30", rd_data.pc); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL squash_refill_count: got %0d want 1", count); end
        rd_yumi = 1'b1;
        tick();
        rd_yumi = 1'b0;
    endtask

    task automatic test_flush();
        wr_valid = 1'b1;
        wr_data  = mk(32'h50, 1'b0); tick();
        wr_data  = mk(32'h54, 1'b0); tick();
        wr_data  = mk(32'h58, 1'b0); tick();
        wr_data  = mk(32'h5C, 1'b0);
        flush    = 1'b1;
        rd_yumi  = 1'b1;
        #1;
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL flush_cycle_valid: got %b want 1", rd_valid); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL flush_count: got %0d want 0", count); end
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL flush_valid: got %b want 0", rd_valid); end
        wr_valid = 1'b1;
        wr_data  = mk(32'h60, 1'b0);
        tick();
        wr_valid = 1'b0;
        #1;
        n_checks++; if (rd_data.pc !== 32'h60) begin n_fail++; $display("FAIL flush_refill_head: got %h want 60", rd_data.pc); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL flush_refill_count: got %0d want 1", count); end
        rd_yumi = 1'b1;
        tick();
        rd_yumi = 1'b0;
    endtask

    task automatic test_async_reset();
        wr_valid = 1'b1;
        wr_data  = mk(32'h80, 1'b0); tick();
        wr_data  = mk(32'h84, 1'b0); tick();
        wr_valid = 1'b0;
        #1;
        n_checks++; if (count !== 3'd2) begin n_fail++; $display("FAIL areset_pre_count: got %0d want 2", count); end
        #2 reset = 1'b0;
        #1;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL areset_valid: got %b want 0", rd_valid); end
        n_checks++; if (wr_ready !== 1'b1) begin n_fail++; $display("FAIL areset_ready: got %b want 1", wr_ready); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL areset_count: got %0d want 0", count); end
        tick();
        reset = 1'b1;
        tick();
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL areset_after_valid: got %b want 0", rd_valid); end
    endtask

    task automatic test_protocol();
        int viol_before;
        viol_before = n_viol;
        rd_yumi = 1'b1;
        tick();
        rd_yumi = 1'b0;
        #1;
        n_checks++; if (n_viol !== viol_before + 1) begin n_fail++; $display("FAIL protocol_flagged: got %0d want %0d", n_viol, viol_before + 1); end
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL protocol_count: got %0d want 0", count); end
        wr_valid = 1'b1;
        wr_data  = mk(32'h70, 1'b0);
        tick();
        wr_valid = 1'b0;
        #1;
        n_checks++; if (rd_data.pc !== 32'h70) begin n_fail++; $display("FAIL protocol_head: got %h want 70", rd_data.pc); end
        n_checks++; if (count !== 3'd1) begin n_fail++; $display("FAIL protocol_refill_count: got %0d want 1", count); end
        rd_yumi = 1'b1;
        tick();
        rd_yumi = 1'b0;
    endtask

`ifdef FETCH_QUEUE_BYPASS_EN
    task automatic test_bypass();
        wr_valid = 1'b1;
        wr_data  = mk(32'h40, 1'b0);
        rd_yumi  = 1'b1;
        #1;
        n_checks++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL bypass_valid: got %b want 1", rd_valid); end
        n_checks++; if (rd_data.pc !== 32'h40) begin n_fail++; $display("FAIL bypass_pc: got %h want 40", rd_data.pc); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL bypass_count: got %0d want 0", count); end
        wr_valid = 1'b1;
        wr_data  = mk(32'h44, 1'b1);
        rd_yumi  = 1'b1;
        #1;
        n_checks++; if (taken_deq !== 1'b1) begin n_fail++; $display("FAIL bypass_taken: got %b want 1", taken_deq); end
        tick();
        rd_yumi = 1'b0;
        flush   = 1'b1;
        wr_data = mk(32'h48, 1'b0);
        #1;
        n_checks++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL bypass_flush_block: got %b want 0", rd_valid); end
        tick();
        idle_inputs();
        #1;
        n_checks++; if (count !== 3'd0) begin n_fail++; $display("FAIL bypass_end_count: got %0d want 0", count); end
    endtask
`endif

    initial begin
        test_reset();
        test_in_order();
        test_full_wrap();
        test_taken_squash();
        test_flush();
        test_async_reset();
        test_protocol();
`ifdef FETCH_QUEUE_BYPASS_EN
        test_bypass();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule : tb_fetch_queue
